// File: rtl/snn_pkg.sv
// Shared constants and FSM state type for the SNN image controller.
package snn_pkg;
  localparam int IMG_BITS  = 784;
  localparam int IMG_BYTES = IMG_BITS / 8;
  localparam int ADDR_W    = 10;

  typedef enum logic [2:0] {RX_WAIT, UNPACK, START, CORE_WAIT, TX} ctrl_state_t;
endpackage

// File: rtl/byte_serializer.sv
// Shifts a loaded byte out LSB-first over 8 cycles; valid marks the 8 bit slots.
module byte_serializer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       bit_out,
  output logic       valid,
  output logic       last
);
  logic [7:0] shift;
  logic [2:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      shift <= byte_in;
      cnt   <= '0;
      valid <= 1'b1;
    end else if (valid) begin
      shift <= {1'b0, shift[7:1]};
      cnt   <= cnt + 3'd1;
      if (cnt == 3'd7) valid <= 1'b0;
    end
  end

  assign bit_out = shift[0];
  assign last    = valid && (cnt == 3'd7);
endmodule

// File: rtl/snn_img_ctrl.sv
// SNN classifier sequencer: UART bytes -> 1-bit input RAM, start core, send digit.
// Build option SNN_CTRL_ASCII_EN: transmit the digit as an ASCII character.
module snn_img_ctrl #(
  parameter int IMG_BITS = snn_pkg::IMG_BITS,
  parameter int ADDR_W   = snn_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              clr_rx_rdy,
  output logic              ram_we,
  output logic              ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [ADDR_W-1:0] core_addr,
  output logic              core_start,
  input  logic              core_done,
  input  logic [3:0]        core_digit,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic [3:0]        last_digit
);
  import snn_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BITS - 1);

  ctrl_state_t       state;
  logic [ADDR_W-1:0] wptr;
  logic              load, ser_last;

  assign load = (state == RX_WAIT) && rx_rdy;

  byte_serializer u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .byte_in (rx_data),
    .bit_out (ram_data),
    .valid   (ram_we),
    .last    (ser_last)
  );

  // The core owns the RAM port whenever the writer is idle, including during reset.
  assign ram_addr = (state == UNPACK) ? wptr : core_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RX_WAIT;
      wptr       <= '0;
      last_digit <= '0;
      clr_rx_rdy <= 1'b0;
      core_start <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
    end else begin
      clr_rx_rdy <= 1'b0;
      core_start <= 1'b0;
      tx_start   <= 1'b0;
      case (state)
        RX_WAIT: if (rx_rdy) begin
          clr_rx_rdy <= 1'b1;
          state      <= UNPACK;
        end
        UNPACK: begin
          // Hold wptr on the final pixel so it never passes IMG_BITS-1.
          if (ser_last && wptr == LAST_ADDR) begin
            core_start <= 1'b1;
            state      <= START;
          end else begin
            wptr <= wptr + 1'b1;
            if (ser_last) state <= RX_WAIT;
          end
        end
        START: begin
          wptr  <= '0;
          state <= CORE_WAIT;
        end
        CORE_WAIT: if (core_done) begin
          last_digit <= core_digit;
          state      <= TX;
        end
        TX: if (!tx_busy) begin
          tx_start <= 1'b1;
`ifdef SNN_CTRL_ASCII_EN
          tx_data  <= 8'h30 + {4'h0, last_digit};
`else
          tx_data  <= {4'h0, last_digit};
`endif
          state    <= RX_WAIT;
        end
        default: state <= RX_WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_snn_img_ctrl.sv
// Directed self-checking bench for snn_img_ctrl with a behavioural input-RAM model.
module tb_snn_img_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = '0;
  logic       clr_rx_rdy, ram_we, ram_data, core_start, tx_start;
  logic [9:0] ram_addr, core_addr = 10'h123;
  logic       core_done = 1'b0, tx_busy = 1'b0;
  logic [3:0] core_digit = '0, last_digit;
  logic [7:0] tx_data;

`ifdef SNN_CTRL_ASCII_EN
  localparam logic [7:0] TX7 = 8'h37, TX9 = 8'h39;
`else
  localparam logic [7:0] TX7 = 8'h07, TX9 = 8'h09;
`endif

  snn_img_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .clr_rx_rdy(clr_rx_rdy), .ram_we(ram_we), .ram_data(ram_data),
    .ram_addr(ram_addr), .core_addr(core_addr), .core_start(core_start),
    .core_done(core_done), .core_digit(core_digit), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .last_digit(last_digit)
  );

  always #5 clk = ~clk;

  bit mem [0:1023];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_data;

  typedef struct {
    logic [7:0] b;
    logic [0:7] seq;  // expected RAM bit for write cycle 0..7
  } vec_t;
  vec_t vecs [5];

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_unpack(input logic [0:7] seq, input int base);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("unpack_we", 32'(ram_we), 1);
      chk("unpack_addr", 32'(ram_addr), base + i);
      chk("unpack_data", 32'(ram_data), 32'(seq[i]));
      chk("unpack_clr", 32'(clr_rx_rdy), (i == 0) ? 1 : 0);
      if (i == 0) rx_rdy = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [0:7] seq, input int base);
    @(negedge clk);
    chk("idle_we", 32'(ram_we), 0);
    rx_rdy  = 1'b1;
    rx_data = b;
    chk_unpack(seq, base);
  endtask

  initial begin
    int bad, seen;
    logic [7:0] txd;
    logic       e;
    vecs[0] = '{8'hA5, 8'b10100101};
    vecs[1] = '{8'h01, 8'b10000000};
    vecs[2] = '{8'h80, 8'b00000001};
    vecs[3] = '{8'h3C, 8'b00111100};
    vecs[4] = '{8'h0F, 8'b11110000};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_clr", 32'(clr_rx_rdy), 0);
    chk("rst_data", 32'(ram_data), 0);
    chk("rst_start", 32'(core_start), 0);
    chk("rst_tx", 32'(tx_start), 0);
    chk("rst_txdata", 32'(tx_data), 0);
    chk("rst_digit", 32'(last_digit), 0);
    chk("rst_addr", 32'(ram_addr), 32'h123);
    rst_n = 1'b1;

    // reset in the middle of an unpack
    @(negedge clk); rx_rdy = 1'b1; rx_data = 8'h5A;
    @(negedge clk); rx_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_we_before", 32'(ram_we), 1);
    rst_n = 1'b0; #1;
    chk("mid_rst_we", 32'(ram_we), 0);
    chk("mid_rst_data", 32'(ram_data), 0);
    chk("mid_rst_clr", 32'(clr_rx_rdy), 0);
    chk("mid_rst_addr", 32'(ram_addr), 32'h123);
    @(negedge clk); rst_n = 1'b1;
    send_byte(8'hFF, 8'b11111111, 0);

    // full image 1: table bytes then 0x01
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int a = 0; a < 1024; a++) mem[a] = 1'b1;
    core_addr = 10'h2AB;
    for (int k = 0; k < 5; k++) send_byte(vecs[k].b, vecs[k].seq, 8 * k);
    for (int k = 5; k < 98; k++) send_byte(8'h01, 8'b10000000, 8 * k);
    @(negedge clk);
    chk("core_start_pulse", 32'(core_start), 1);
    chk("start_we", 32'(ram_we), 0);
    @(negedge clk);
    chk("core_start_single", 32'(core_start), 0);
    core_addr = 10'h0F0; #1;
    chk("mux_core_a", 32'(ram_addr), 32'h0F0);
    core_addr = 10'h30F; #1;
    chk("mux_core_b", 32'(ram_addr), 32'h30F);
    bad = 0;
    for (int a = 0; a < 784; a++) begin
      e = (a < 40) ? vecs[a / 8].seq[a % 8] : ((a % 8) == 0);
      if (mem[a] !== e) bad++;
    end
    chk("image_mem", 32'(bad), 0);

    // result transmit
    @(negedge clk); core_done = 1'b1; core_digit = 4'd7;
    @(negedge clk); core_done = 1'b0;
    chk("last_digit_7", 32'(last_digit), 7);
    seen = 0; txd = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tx_start) begin seen++; txd = tx_data; end
    end
    chk("tx_pulse_count", 32'(seen), 1);
    chk("tx_data_7", 32'(txd), 32'(TX7));

    // image 2: done during START, held byte, backpressure
    for (int k = 0; k < 98; k++) send_byte(8'h01, 8'b10000000, 8 * k);
    @(negedge clk);
    chk("core_start_2", 32'(core_start), 1);
    core_done = 1'b1; core_digit = 4'd3;
    @(negedge clk); core_done = 1'b0;
    chk("done_in_start_ignored", 32'(last_digit), 7);
    rx_rdy = 1'b1; rx_data = 8'h81; tx_busy = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (clr_rx_rdy || ram_we) bad++;
    end
    core_done = 1'b1; core_digit = 4'd9;
    @(negedge clk); core_done = 1'b0;
    chk("last_digit_9", 32'(last_digit), 9);
    repeat (20) begin
      @(negedge clk);
      if (tx_start || clr_rx_rdy || ram_we) bad++;
    end
    chk("busy_and_held_quiet", 32'(bad), 0);
    tx_busy = 1'b0;
    @(negedge clk);
    chk("tx_after_busy", 32'(tx_start), 1);
    chk("tx_data_9", 32'(tx_data), 32'(TX9));
    chk("held_no_clr_yet", 32'(clr_rx_rdy), 0);
    chk_unpack(8'b10000001, 0);
    @(negedge clk);
    chk("held_done_we", 32'(ram_we), 0);
    chk("tx_single_2", 32'(tx_start), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
